// File: rtl/bram_rd_checker.sv
`timescale 1ns/1ps
// Read-side BRAM checker: aligns each read address with the port-B latency and checks data == addr << 1.
// Optional sticky HALT on first mismatch when CHK_HALT_ON_ERR_EN is defined.
module bram_rd_checker #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 10,
  parameter int RD_LATENCY = 1,
  parameter int SETTLE_CYC = 1024,
  parameter int PASS_COUNT = 4096
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic              locked,
  input  logic              chk_en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [15:0]       chk_cnt,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              busy,
  output logic              pass,
  output logic              fail
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
`ifdef CHK_HALT_ON_ERR_EN
    , ST_HALT = 2'd3
`endif
  } state_t;

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] s;
    s = {a, 1'b0};
    return DATA_W'(s);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [RD_LATENCY-1:0] dl_v_q;
  logic [ADDR_W-1:0]   dl_a_q [RD_LATENCY];
  logic [15:0]         chk_q, chk_d, err_q, err_d;
  logic [ADDR_W-1:0]   fa_q, fa_d;
  logic [DATA_W-1:0]   fd_q, fd_d;
  logic                busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
  logic                samp_v, cmp_v, mism, flush;

  always_comb begin
    samp_v   = chk_en & locked & (state_q == ST_CHECK);
    cmp_v    = dl_v_q[RD_LATENCY-1] & locked & (state_q == ST_CHECK);
    mism     = cmp_v & (rd_data != exp_data(dl_a_q[RD_LATENCY-1]));
    state_d  = state_q;
    settle_d = '0;
    chk_d    = chk_q;
    err_d    = err_q;
    fa_d     = fa_q;
    fd_d     = fd_q;

    case (state_q)
      ST_IDLE: begin
        if (locked) state_d = ST_SETTLE;
        else        state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (!locked)                     state_d = ST_IDLE;
        else if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
        else                             settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
      end
      ST_CHECK: begin
        if (!locked) state_d = ST_IDLE;
`ifdef CHK_HALT_ON_ERR_EN
        else if (mism) state_d = ST_HALT;
`endif
        else state_d = ST_CHECK;
      end
`ifdef CHK_HALT_ON_ERR_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase

    if (cmp_v) chk_d = sat_inc(chk_q);
    else       chk_d = chk_q;
    if (mism) begin
      err_d = sat_inc(err_q);
      if (err_q == 16'd0) begin
        fa_d = dl_a_q[RD_LATENCY-1];
        fd_d = rd_data;
      end else begin
        fa_d = fa_q;
        fd_d = fd_q;
      end
    end else begin
      err_d = err_q;
    end

    // clr wins over any compare landing in the same cycle
    if (clr) begin
      state_d  = locked ? ST_SETTLE : ST_IDLE;
      settle_d = '0;
      chk_d    = 16'd0;
      err_d    = 16'd0;
      fa_d     = '0;
      fd_d     = '0;
    end else begin
      settle_d = settle_d;
    end

    flush  = clr | (state_d != ST_CHECK);
    busy_d = (state_d == ST_SETTLE) | (state_d == ST_CHECK);
    pass_d = (chk_d >= 16'(PASS_COUNT)) & (err_d == 16'd0);
    fail_d = (err_d != 16'd0);
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      chk_q    <= 16'd0;
      err_q    <= 16'd0;
      fa_q     <= '0;
      fd_q     <= '0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fd_q     <= fd_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  // Address/valid delay line matching the BRAM read latency; valids dropped when checking stops
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      dl_v_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dl_a_q[i] <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        dl_v_q[i] <= flush ? 1'b0 : dl_v_q[i-1];
        dl_a_q[i] <= dl_a_q[i-1];
      end
      dl_v_q[0] <= flush ? 1'b0 : samp_v;
      dl_a_q[0] <= rd_addr;
    end
  end

  assign chk_cnt        = chk_q;
  assign err_cnt        = err_q;
  assign first_err_addr = fa_q;
  assign first_err_data = fd_q;
  assign busy           = busy_q;
  assign pass           = pass_q;
  assign fail           = fail_q;

endmodule

// File: tb/tb_bram_rd_checker.sv
`timescale 1ns/1ps
// Directed bench for bram_rd_checker with a latency-2 BRAM model (data = addr << 1, optional corruption).
module tb_bram_rd_checker;

  logic        clk_in1 = 1'b0;
  logic        reset, locked, chk_en, clr;
  logic [9:0]  rd_addr, rd_data;
  logic [15:0] chk_cnt, err_cnt;
  logic [9:0]  first_err_addr, first_err_data;
  logic        busy, pass, fail;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [9:0] hist0 = 10'd0, hist1 = 10'd0;
  logic       ramp  = 1'b0;
  logic       bad_en = 1'b0;
  logic [9:0] bad_a = 10'd0, bad_d = 10'd0;

  bram_rd_checker #(
    .ADDR_W(10), .DATA_W(10), .RD_LATENCY(2), .SETTLE_CYC(16), .PASS_COUNT(20)
  ) dut (
    .clk_in1(clk_in1), .reset(reset), .locked(locked), .chk_en(chk_en), .clr(clr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .busy(busy), .pass(pass), .fail(fail)
  );

  always #5 clk_in1 = ~clk_in1;

  function automatic logic [9:0] mk(input logic [9:0] a);
    if (bad_en && a == bad_a) return bad_d;
    else                      return {a[8:0], 1'b0};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in1);
    #1;
    hist1   = hist0;
    hist0   = rd_addr;
    rd_data = mk(hist1);
    if (ramp) rd_addr = rd_addr + 10'd1;
  endtask

  task automatic wait_chk(input logic [15:0] base, input int start, output int n);
    n = start;
    while (chk_cnt == base && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_err(input logic [15:0] base);
    int n;
    n = 0;
    while (err_cnt == base && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] c;
    reset = 1'b1; locked = 1'b0; chk_en = 1'b0; clr = 1'b0;
    rd_addr = 10'd0; rd_data = 10'd0;

    // 1: reset, then idle with locked low
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    check_val("rst_chk", chk_cnt, 0);
    check_val("rst_err", err_cnt, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pass", pass, 0);
    check_val("rst_fail", fail, 0);
    check_val("rst_faddr", first_err_addr, 0);

    // 2: lock, settle, first check latency, pass threshold
    chk_en = 1'b1; ramp = 1'b1; locked = 1'b1;
    tick();
    check_val("busy_c1", busy, 1);
    check_val("chk_c1", chk_cnt, 0);
    wait_chk(16'd0, 1, n);
    check_val("first_chk_lat", n, 20);
    check_val("first_chk", chk_cnt, 1);
    repeat (18) tick();
    check_val("chk_19", chk_cnt, 19);
    check_val("pass_19", pass, 0);
    tick();
    check_val("chk_20", chk_cnt, 20);
    check_val("pass_20", pass, 1);
    check_val("fail_20", fail, 0);

    // 3: corrupted read at 0x005, then a second error
    rd_addr = 10'd0; bad_en = 1'b1; bad_a = 10'h005; bad_d = 10'h00B;
    wait_err(16'd0);
    check_val("err1", err_cnt, 1);
    check_val("faddr1", first_err_addr, 10'h005);
    check_val("fdata1", first_err_data, 10'h00B);
    check_val("fail1", fail, 1);
    check_val("pass1", pass, 0);
    bad_a = 10'h014; bad_d = 10'h055;
    wait_err(16'd1);
    check_val("err2", err_cnt, 2);
    check_val("faddr2", first_err_addr, 10'h005);
    check_val("fdata2", first_err_data, 10'h00B);
    bad_en = 1'b0;

    // 4: address wrap and 0x200 -> 0x000
    rd_addr = 10'h3FC;
    c = chk_cnt;
    repeat (8) tick();
    check_val("wrap_chk", chk_cnt, c + 16'd8);
    check_val("wrap_err", err_cnt, 2);
    rd_addr = 10'h1FC;
    repeat (8) tick();
    check_val("a200_err", err_cnt, 2);

    // 5: drop lock with reads in flight, then relock
    c = chk_cnt;
    locked = 1'b0;
    tick();
    check_val("unlock_busy", busy, 0);
    repeat (3) tick();
    check_val("unlock_chk", chk_cnt, c);
    check_val("unlock_err", err_cnt, 2);
    check_val("unlock_faddr", first_err_addr, 10'h005);
    check_val("unlock_fail", fail, 1);
    locked = 1'b1;
    tick();
    check_val("relock_busy", busy, 1);
    wait_chk(c, 1, n);
    check_val("relock_lat", n, 20);
    check_val("relock_err", err_cnt, 2);

    // 6: async reset mid-cycle, then clr after an error
    tick();
    #2 reset = 1'b1;
    #1;
    check_val("arst_chk", chk_cnt, 0);
    check_val("arst_err", err_cnt, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_fail", fail, 0);
    check_val("arst_faddr", first_err_addr, 0);
    #1 reset = 1'b0;
    wait_chk(16'd0, 0, n);
    check_val("post_rst_lat", n, 20);
    bad_en = 1'b1; bad_a = rd_addr + 10'd3; bad_d = 10'h3FF;
    wait_err(16'd0);
    check_val("e6_err", err_cnt, 1);
    check_val("e6_faddr", first_err_addr, bad_a);
    check_val("e6_fdata", first_err_data, 10'h3FF);
    bad_en = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_chk", chk_cnt, 0);
    check_val("clr_err", err_cnt, 0);
    check_val("clr_fail", fail, 0);
    check_val("clr_faddr", first_err_addr, 0);
    check_val("clr_busy", busy, 1);
    wait_chk(16'd0, 1, n);
    check_val("clr_lat", n, 20);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
